mu0_memory_io: RTL

Zero-wait-state memory and I/O slave for the MU0 CPU bus. Holds a 4096×16 word-addressed RAM serving instruction fetches and data accesses, plus two memory-mapped I/O words: an output port feeding a small FIFO drained by a ready/valid consumer, and a status word. `readdata` is combinational, so the CPU sees data in the same cycle it drives `address`/`read`.

---
 rtl/mu0_bus_pkg.sv | 7 +
 rtl/mu0_out_fifo.sv | 49 ++++
 rtl/mu0_memory_io.sv | 62 ++++++
 3 files changed

// File: rtl/mu0_bus_pkg.sv
// MU0 bus constants shared by the memory/I-O slave and its output FIFO.
package mu0_bus_pkg;
  localparam int ADDR_W = 12;
  localparam int WORD_W = 16;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 12'hFFE;
  localparam logic [ADDR_W-1:0] ADDR_OUT    = 12'hFFF;
endpackage

// File: rtl/mu0_out_fifo.sv
// Output-port FIFO: explicit count (one extra bit) separates full from empty.
module mu0_out_fifo
  import mu0_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [WORD_W-1:0]        head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WORD_W-1:0] store [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic              pop, push_ok;

  assign valid   = (count != '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop     = valid && ready;
  // A pop frees the slot in the same edge, so a full FIFO can still take a push.
  assign push_ok = push && (!full || pop);
  assign head    = valid ? store[rptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store[wptr] <= push_data;
  end
endmodule

// File: rtl/mu0_memory_io.sv
// Zero-wait-state MU0 RAM plus memory-mapped OUT FIFO and STATUS word.
module mu0_memory_io
  import mu0_bus_pkg::*;
#(
  parameter string RAM_INIT_FILE = "",
  parameter int    FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic              read,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic              is_status, is_out, is_ram;
  logic              out_push, fifo_full, overflow, ovf_set;
  logic [CW-1:0]     fifo_count;

  assign is_status = (address == ADDR_STATUS);
  assign is_out    = (address == ADDR_OUT);
  assign is_ram    = !is_status && !is_out;
  assign out_push  = write && is_out;
  // A full FIFO only drops the word when nothing drains it this edge.
  assign ovf_set   = out_push && fifo_full && !out_ready;

  always_ff @(posedge clk) begin
    if (write && is_ram) mem[address] <= writedata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         overflow <= 1'b0;
    else if (ovf_set)                overflow <= 1'b1;
    else if (read && is_status)      overflow <= 1'b0;
  end

  always_comb begin
    readdata = '0;
    if (read) begin
      if (is_status)   readdata = {overflow, 15'(fifo_count)};
      else if (is_ram) readdata = mem[address];
    end
  end

  mu0_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push),
    .push_data (writedata),
    .ready     (out_ready),
    .valid     (out_valid),
    .head      (out_data),
    .full      (fifo_full),
    .count     (fifo_count)
  );
endmodule
